regbank_sb: RTL and testbench
=============================

Name: regbank_sb

Overview:
- Parametrised successor to the 32x32 two-read/one-write MIPS register bank.
- Configurable width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection.
- Sits between the decode stage (reads, reservations) and writeback (writes) of the MIPS datapath.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data; 0 = returns the old value

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- ra  in  NUM_RD x ADDR_W  read addresses
- rd  out  NUM_RD x DATA_W  read data, combinational
- rd_busy  out  NUM_RD  scoreboard busy bit of ra[i], combinational
- we  in  NUM_WR  write enables
- wa  in  NUM_WR x ADDR_W  write addresses
- wd  in  NUM_WR x DATA_W  write data
- rsv_en  in  1  reserve a destination register (mark busy)
- rsv_addr  in  ADDR_W  register to reserve
- rd_perr  out  NUM_RD  parity error on read port i (see Optional Feature)

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: when rst=1 at a rising clk edge, all registers clear to 0 and all busy bits clear to 0. Reset overrides any write or reservation in the same cycle. Outputs are combinational from state, so after reset rd=0, rd_busy=0 and rd_perr=0.
- Register 0:
  - always reads 0 and is never busy;
  - writes and reservations to address 0 are ignored.
- Write:
  - on a rising edge with we[j]=1 and wa[j]!=0, reg[wa[j]] <= wd[j];
  - write latency is 1 cycle.
- Write conflict: when both write ports target the same address in one cycle, the higher-index port wins.
- Read: rd[i] = reg[ra[i]], combinational (zero-cycle latency).
- Bypass (BYPASS=1): if any we[j]=1 with wa[j]==ra[i]!=0, rd[i] returns that wd[j] (highest j on conflict) in the same cycle. With BYPASS=0, rd[i] shows the old value until the next cycle.
- Scoreboard, one busy bit per register:
  - rsv_en=1 with rsv_addr!=0 sets busy[rsv_addr] at the edge;
  - a write (we[j]=1) to an address clears its busy bit at the edge;
  - same-cycle reserve and write to the same address: the reservation wins and busy stays 1 (a new producer is in flight);
  - a write to a non-busy register is legal and leaves busy at 0;
  - reserving an already-busy register is legal and leaves busy at 1.
- rd_busy[i] = busy[ra[i]], combinational. It is not bypassed: a write in the current cycle does not clear rd_busy until the next cycle.
- There is no handshake and no backpressure; every edge completes its operations.

Optional Feature:
- Macro: REGBANK_PARITY_EN.
- Defined:
  - each register stores an extra even-parity bit, computed from wd on write and cleared to 0 on reset;
  - on read, rd_perr[i]=1 if the recomputed parity of the stored data differs from the stored bit;
  - bypassed reads and register 0 always report rd_perr=0.
- Undefined: no parity storage; rd_perr is tied to 0. The port stays present so the port list does not change.

Decomposition:
- Package regbank_pkg:
  - default constants DATA_W_DEF=32, ADDR_W_DEF=5;
  - typedef reg_addr_t (logic [ADDR_W_DEF-1:0]);
  - typedef reg_data_t (logic [DATA_W_DEF-1:0]);
  - constant REG_ZERO = '0.
- Sub-module regbank_scoreboard owns the busy-bit vector, set/clear priority, reset, and the rd_busy lookups.
- regbank_sb keeps storage, write arbitration, bypass and parity.

Test Plan:
- Reset, then read all addresses on both ports -> rd=0x00000000, rd_busy=0, rd_perr=0 everywhere.
- Write 0xDEADBEEF to r5, then read r5 and r0 the next cycle -> rd[0]=0xDEADBEEF; r0 stays 0 even after writing 0x12345678 to it.
- BYPASS=1: write 0xCAFEF00D to r7 with ra[1]=7 in the same cycle -> rd[1]=0xCAFEF00D that cycle. BYPASS=0 -> old value that cycle, new value the next.
- NUM_WR=2: both ports write r9 (0x11111111 on port 0, 0x22222222 on port 1) -> r9=0x22222222.
- Scoreboard:
  - reserve r3 -> rd_busy=1 next cycle;
  - write r3 -> busy clears the following cycle;
  - reserve and write r3 in the same cycle -> busy stays 1;
  - reserve r0 -> busy stays 0.
- Assert rst mid-sequence with we=1 to r4 (0xFFFFFFFF) and rsv_en to r4 -> r4=0 and not busy after the edge. With REGBANK_PARITY_EN, force a stored bit flip in r4 -> rd_perr=1 on the port reading r4.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and types for the regbank_sb register bank and its scoreboard.
// The REGBANK_PARITY_EN macro (see regbank_sb.sv) enables per-register parity.
package regbank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register busy bits for hazard detection: set by a decode-stage reservation,
// cleared by a writeback write, with reservation winning a same-cycle tie.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic [NUM_RD-1:0]              rd_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Clears are applied first so a reservation of the same register overrides them:
    // a new producer is in flight even though an older one is retiring.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j]) begin
                busy_nxt[wa[j]] = 1'b0;
            end
        end
        if (rsv_en) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    // Lookups are deliberately not bypassed: a retiring write is visible next cycle.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_busy[i] = busy[ra[i]];
        end
    end

endmodule

// File: rtl/regbank_sb.sv
// Parametrised multi-port register bank with write-to-read bypass and busy scoreboard.
// Define REGBANK_PARITY_EN to store an even-parity bit per register and flag read errors.
module regbank_sb
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1,
    parameter int BYPASS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  ra,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic [NUM_WR-1:0]              we,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wa,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wd,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic [NUM_RD-1:0]              rd_perr
);

    localparam int DEPTH = 1 << ADDR_W;

    // No handshake: every read, write and reservation presented at an edge completes there.

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_data [DEPTH];

    logic [NUM_RD-1:0] byp_hit;
    logic [DATA_W-1:0] byp_data [NUM_RD];

    // Per-register write decode; scanning ports upward lets the highest port win a conflict.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wr_hit[a]  = 1'b0;
            wr_data[a] = '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j] && (wa[j] != '0)) begin
                wr_hit[wa[j]]  = 1'b1;
                wr_data[wa[j]] = wd[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_hit[a]) begin
                    mem[a] <= wr_data[a];
                end
            end
        end
    end

    // Bypass match uses the same upward scan so a read sees the value that will be stored.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            byp_hit[i]  = 1'b0;
            byp_data[i] = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if ((BYPASS != 0) && we[j] && (wa[j] == ra[i]) && (ra[i] != '0)) begin
                    byp_hit[i]  = 1'b1;
                    byp_data[i] = wd[j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (ra[i] == '0) begin
                rd[i] = '0;
            end else if (byp_hit[i]) begin
                rd[i] = byp_data[i];
            end else begin
                rd[i] = mem[ra[i]];
            end
        end
    end

`ifdef REGBANK_PARITY_EN
    // par[a] makes data plus parity carry an even number of ones.
    logic [DEPTH-1:0] par;

    always_ff @(posedge clk) begin
        if (rst) begin
            par <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr_hit[a]) begin
                    par[a] <= ^wr_data[a];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_perr[i] = (ra[i] != '0) && !byp_hit[i] && ((^mem[ra[i]]) != par[ra[i]]);
        end
    end
`else
    assign rd_perr = '0;
`endif

    regbank_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra),
        .we       (we),
        .wa       (wa),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_regbank_sb.sv
// Directed bench for regbank_sb: a bypassing two-write instance and a non-bypassing twin
// share all inputs; expected values come from hand-computed vector tables.
module tb_regbank_sb;
    import regbank_pkg::*;

    typedef struct {
        logic [1:0] we;
        reg_addr_t  wa0;
        reg_data_t  wd0;
        reg_addr_t  wa1;
        reg_data_t  wd1;
        logic       rsv_en;
        reg_addr_t  rsv_addr;
        reg_addr_t  ra0;
        reg_addr_t  ra1;
        reg_data_t  e_rd0;
        reg_data_t  e_rd1;
        reg_data_t  e_nb_rd1;
        logic [1:0] e_busy;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0][4:0]      ra;
    logic [1:0][31:0]     rd;
    logic [1:0][31:0]     rd_nb;
    logic [1:0]           rd_busy;
    logic [1:0]           busy_nb;
    logic [1:0]           rd_perr;
    logic [1:0]           perr_nb;
    logic [1:0]           we;
    logic [1:0][4:0]      wa;
    logic [1:0][31:0]     wd;
    logic                 rsv_en;
    logic [4:0]           rsv_addr;

    logic [31:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        vecs[21];

    regbank_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy), .we(we), .wa(wa),
        .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_perr(rd_perr)
    );

    regbank_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_nb), .rd_busy(busy_nb), .we(we), .wa(wa),
        .wd(wd), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_perr(perr_nb)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive_idle();
        we       = 2'b00;
        wa       = '0;
        wd       = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        we       = v.we;
        wa[0]    = v.wa0;
        wd[0]    = v.wd0;
        wa[1]    = v.wa1;
        wd[1]    = v.wd1;
        rsv_en   = v.rsv_en;
        rsv_addr = v.rsv_addr;
        ra[0]    = v.ra0;
        ra[1]    = v.ra1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    task automatic check_data(input string name, input int idx, input logic [31:0] act);
        logic [31:0] exp;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, expected-value queue empty", name, idx, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_err++;
                $display("FAIL %s #%0d: got %h required %h", name, idx, act, exp);
            end
        end
    endtask

    task automatic check_bits(input string name, input int idx, input logic [1:0] act,
                              input logic [1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %b required %b", name, idx, act, exp);
        end
    endtask

    initial begin
        // we, wa0, wd0, wa1, wd1, rsv_en, rsv_addr, ra0, ra1, e_rd0, e_rd1, e_nb_rd1, e_busy
        vecs[0]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00};
        vecs[1]  = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,        1'b0, 5'd0, 5'd6, 5'd0, 32'h0,        32'h0,        32'h0,        2'b00};
        vecs[2]  = '{2'b01, 5'd0, 32'h12345678, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00};
        vecs[3]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        2'b00};
        vecs[4]  = '{2'b01, 5'd7, 32'hCAFEF00D, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,        2'b00};
        vecs[5]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00};
        vecs[6]  = '{2'b11, 5'd9, 32'h11111111, 5'd9, 32'h22222222, 1'b0, 5'd0, 5'd9, 5'd9, 32'h22222222, 32'h22222222, 32'h0,        2'b00};
        vecs[7]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h22222222, 32'h22222222, 32'h22222222, 2'b00};
        vecs[8]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd5, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vecs[9]  = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd0, 32'h0,        32'h0,        32'h0,        2'b01};
        vecs[10] = '{2'b01, 5'd3, 32'h00000033, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h00000033, 32'h00000033, 32'h0,        2'b11};
        vecs[11] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h00000033, 32'h00000033, 32'h00000033, 2'b00};
        vecs[12] = '{2'b01, 5'd3, 32'h00000044, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd9, 32'h00000044, 32'h22222222, 32'h22222222, 2'b00};
        vecs[13] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd9, 32'h00000044, 32'h22222222, 32'h22222222, 2'b01};
        vecs[14] = '{2'b10, 5'd0, 32'h0,        5'd3, 32'h00000055, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0,        32'h00000055, 32'h00000044, 2'b10};
        vecs[15] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd3, 32'h0,        32'h00000055, 32'h00000055, 2'b00};
        vecs[16] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h00000055, 32'h00000055, 32'h00000055, 2'b00};
        vecs[17] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd3, 32'h00000055, 32'h00000055, 32'h00000055, 2'b11};
        vecs[18] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd9, 32'h00000055, 32'h22222222, 32'h22222222, 2'b01};
        vecs[19] = '{2'b00, 5'd5, 32'h0BADF00D, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        vecs[20] = '{2'b00, 5'd0, 32'h0,        5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};

        rst = 1'b1;
        ra  = '0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Every address reads zero, idle and error-free after reset
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a);
            ra[1] = 5'(31 - a);
            #1;
            exp_q.push_back(32'h0);
            exp_q.push_back(32'h0);
            check_data("reset_rd0", a, rd[0]);
            check_data("reset_rd1", a, rd[1]);
            check_bits("reset_busy", a, rd_busy, 2'b00);
            check_bits("reset_perr", a, rd_perr, 2'b00);
        end

        for (int k = 0; k < 21; k++) begin
            drive_vec(vecs[k]);
            #1;
            exp_q.push_back(vecs[k].e_rd0);
            exp_q.push_back(vecs[k].e_rd1);
            exp_q.push_back(vecs[k].e_nb_rd1);
            check_data("rd0", k, rd[0]);
            check_data("rd1", k, rd[1]);
            check_data("nobypass_rd1", k, rd_nb[1]);
            check_bits("busy", k, rd_busy, vecs[k].e_busy);
            check_bits("nobypass_busy", k, busy_nb, vecs[k].e_busy);
            check_bits("perr", k, rd_perr, 2'b00);
            check_bits("nobypass_perr", k, perr_nb, 2'b00);
            next_cycle();
        end

        // Reset wins over a same-cycle write and reservation of r4
        drive_idle();
        we[0]    = 1'b1;
        wa[0]    = 5'd4;
        wd[0]    = 32'hFFFFFFFF;
        rsv_en   = 1'b1;
        rsv_addr = 5'd4;
        rst      = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive_idle();
        ra[0] = 5'd4;
        ra[1] = 5'd5;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        check_data("midreset_r4", 0, rd[0]);
        check_data("midreset_r5", 0, rd[1]);
        check_bits("midreset_busy", 0, rd_busy, 2'b00);
        check_bits("midreset_perr", 0, rd_perr, 2'b00);

`ifdef REGBANK_PARITY_EN
        // A flipped stored bit in r4 must be flagged on the port reading r4
        ra[0] = 5'd5;
        ra[1] = 5'd4;
        dut.mem[4] = 32'h00000001;
        #1;
        check_bits("parity_flip", 0, rd_perr, 2'b10);
        ra[0] = 5'd4;
        ra[1] = 5'd0;
        #1;
        check_bits("parity_flip_p0", 0, rd_perr, 2'b01);
`endif

        next_cycle();
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expected: %0d entries remain, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
